mtvec_trap_unit: RTL and testbench

Parametrised machine-mode trap unit that succeeds the single mtvec register.
- Holds mtvec, mepc and mcause, with WARL legalisation on each.
- Captures trap context on a trap request and computes the direct or vectored handler address.
- Drives a ready/valid PC-redirect handshake to fetch for both trap entry and mret.
- Sits beside the CSR file, between decode/execute (trap and mret sources) and the fetch PC mux.

---
 rtl/mtvec_trap_unit_pkg.sv | 32 +++
 rtl/mtvec_trap_unit_target_calc.sv | 29 ++
 rtl/mtvec_trap_unit.sv | 144 ++++++++++++++
 tb/tb_mtvec_trap_unit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtvec_trap_unit_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses,
// mtvec mode encodings, FSM state encoding and the mtvec mode WARL rule.
package mtvec_trap_unit_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [1:0] MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MODE_VECTORED = 2'b01;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } trap_state_e;

    // Direct is always accepted, vectored only when enabled; anything else
    // leaves the previously stored mode untouched.
    function automatic logic [1:0] legal_mode(input logic [1:0] old_mode,
                                              input logic [1:0] wr_mode,
                                              input logic       vec_en);
        logic [1:0] mode;
        mode = old_mode;
        if (wr_mode == MODE_DIRECT) begin
            mode = MODE_DIRECT;
        end else if ((wr_mode == MODE_VECTORED) && vec_en) begin
            mode = MODE_VECTORED;
        end
        return mode;
    endfunction

endpackage

// File: rtl/mtvec_trap_unit_target_calc.sv
// Handler address generation: aligned mtvec base, plus cause*4 when the
// trap is an interrupt and mtvec is in vectored mode. The sum wraps.
module mtvec_trap_unit_target_calc
    import mtvec_trap_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CAUSE_W = 4
) (
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic               int_i,
    input  logic [CAUSE_W-1:0] cause_i,
    output logic [XLEN-1:0]    target_o
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    // Select between the plain base and the vectored entry for interrupts.
    always_comb begin
        base   = {mtvec_i[XLEN-1:2], 2'b00};
        offset = {{(XLEN-CAUSE_W-2){1'b0}}, cause_i, 2'b00};
        if ((mtvec_i[1:0] == MODE_VECTORED) && int_i) begin
            target_o = base + offset;
        end else begin
            target_o = base;
        end
    end

endmodule

// File: rtl/mtvec_trap_unit.sv
// Machine-mode trap unit: holds mtvec/mepc/mcause, captures trap context,
// and drives a ready/valid PC redirect towards fetch for traps and mret.
module mtvec_trap_unit
    import mtvec_trap_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CAUSE_W     = 4,
    parameter bit              VEC_EN      = 1'b1,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [11:0]     MTVEC_ADDR  = CSR_MTVEC,
    parameter logic [11:0]     MEPC_ADDR   = CSR_MEPC,
    parameter logic [11:0]     MCAUSE_ADDR = CSR_MCAUSE
) (
    input  logic               clock,
    input  logic               rst_n_in,
    input  logic               csr_wr_en_in,
    input  logic [11:0]        csr_addr_in,
    input  logic [XLEN-1:0]    csr_wr_data_in,
    output logic [XLEN-1:0]    csr_rd_data_out,
    input  logic               trap_req_in,
    input  logic               int_or_exc_in,
    input  logic [CAUSE_W-1:0] cause_in,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               mret_in,
    output logic               trap_ack_out,
    output logic               mret_ack_out,
    output logic               redirect_valid_out,
    input  logic               redirect_ready_in,
    output logic [XLEN-1:0]    redirect_pc_out,
    output logic [XLEN-1:0]    mtvec_out,
    output logic [XLEN-1:0]    mepc_out,
    output logic [XLEN-1:0]    mcause_out,
    output logic               busy_out
);

    localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MCAUSE_MASK = {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, {CAUSE_W{1'b1}}};
    // The reset mode goes through the same legalisation as a CSR write so a
    // vectored reset value cannot survive when vectoring is disabled.
    localparam logic [XLEN-1:0] MTVEC_RESET_LEGAL =
        {MTVEC_RESET[XLEN-1:2], legal_mode(MODE_DIRECT, MTVEC_RESET[1:0], VEC_EN)};

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] trap_target;
    logic            trap_accept;
    logic            mret_accept;

    mtvec_trap_unit_target_calc #(
        .XLEN    (XLEN),
        .CAUSE_W (CAUSE_W)
    ) u_target_calc (
        .mtvec_i  (mtvec_q),
        .int_i    (int_or_exc_in),
        .cause_i  (cause_in),
        .target_o (trap_target)
    );

    // Next-state logic: CSR writes first, then trap/mret capture in IDLE so
    // that a capture overrides a same-cycle mepc/mcause write.
    always_comb begin
        state_d       = state_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        redirect_pc_d = redirect_pc_q;
        trap_accept   = 1'b0;
        mret_accept   = 1'b0;

        if (csr_wr_en_in) begin
            case (csr_addr_in)
                MTVEC_ADDR:  mtvec_d  = {csr_wr_data_in[XLEN-1:2],
                                         legal_mode(mtvec_q[1:0], csr_wr_data_in[1:0], VEC_EN)};
                MEPC_ADDR:   mepc_d   = csr_wr_data_in & ALIGN_MASK;
                MCAUSE_ADDR: mcause_d = csr_wr_data_in & MCAUSE_MASK;
                default:     ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (trap_req_in) begin
                    trap_accept   = 1'b1;
                    mepc_d        = pc_in & ALIGN_MASK;
                    mcause_d      = {int_or_exc_in, {(XLEN-1-CAUSE_W){1'b0}}, cause_in};
                    redirect_pc_d = trap_target;
                    state_d       = REDIRECT;
                end else if (mret_in) begin
                    mret_accept   = 1'b1;
                    redirect_pc_d = mepc_q;
                    state_d       = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and CSR registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clock or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            mtvec_q       <= MTVEC_RESET_LEGAL;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Combinational CSR read port; unmapped addresses read as zero.
    always_comb begin
        csr_rd_data_out = '0;
        case (csr_addr_in)
            MTVEC_ADDR:  csr_rd_data_out = mtvec_q;
            MEPC_ADDR:   csr_rd_data_out = mepc_q;
            MCAUSE_ADDR: csr_rd_data_out = mcause_q;
            default:     csr_rd_data_out = '0;
        endcase
    end

    // Acks are suppressed while reset is held so no strobe leaks out.
    assign trap_ack_out       = trap_accept & rst_n_in;
    assign mret_ack_out       = mret_accept & rst_n_in;
    assign redirect_valid_out = (state_q == REDIRECT);
    assign busy_out           = (state_q != IDLE);
    assign redirect_pc_out    = redirect_pc_q;
    assign mtvec_out          = mtvec_q;
    assign mepc_out           = mepc_q;
    assign mcause_out         = mcause_q;

endmodule

// File: tb/tb_mtvec_trap_unit.sv
// Self-checking bench for mtvec_trap_unit. A second instance with vectoring
// disabled shares all inputs so both mode policies are seen side by side.
module tb_mtvec_trap_unit;

    logic        clock = 1'b0;
    logic        rstN = 1'b1;
    logic        csrWrEn = 1'b0;
    logic [11:0] csrAddr = 12'h000;
    logic [31:0] csrWrData = 32'h0;
    logic        trapReq = 1'b0;
    logic        intOrExc = 1'b0;
    logic [3:0]  cause = 4'h0;
    logic [31:0] pc = 32'h0;
    logic        mretReq = 1'b0;
    logic        redirectReady = 1'b0;

    logic [31:0] csrRdData, redirectPc, mtvecOut, mepcOut, mcauseOut;
    logic        trapAck, mretAck, redirectValid, busy;
    logic [31:0] csrRdDataNv, redirectPcNv, mtvecOutNv, mepcOutNv, mcauseOutNv;
    logic        trapAckNv, mretAckNv, redirectValidNv, busyNv;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] mtvecModel, mtvecModelNv, mepcModel, mcauseModel;

    mtvec_trap_unit #(.VEC_EN(1'b1)) dut (
        .clock(clock), .rst_n_in(rstN), .csr_wr_en_in(csrWrEn), .csr_addr_in(csrAddr),
        .csr_wr_data_in(csrWrData), .csr_rd_data_out(csrRdData), .trap_req_in(trapReq),
        .int_or_exc_in(intOrExc), .cause_in(cause), .pc_in(pc), .mret_in(mretReq),
        .trap_ack_out(trapAck), .mret_ack_out(mretAck), .redirect_valid_out(redirectValid),
        .redirect_ready_in(redirectReady), .redirect_pc_out(redirectPc), .mtvec_out(mtvecOut),
        .mepc_out(mepcOut), .mcause_out(mcauseOut), .busy_out(busy)
    );

    mtvec_trap_unit #(.VEC_EN(1'b0)) dutNv (
        .clock(clock), .rst_n_in(rstN), .csr_wr_en_in(csrWrEn), .csr_addr_in(csrAddr),
        .csr_wr_data_in(csrWrData), .csr_rd_data_out(csrRdDataNv), .trap_req_in(trapReq),
        .int_or_exc_in(intOrExc), .cause_in(cause), .pc_in(pc), .mret_in(mretReq),
        .trap_ack_out(trapAckNv), .mret_ack_out(mretAckNv), .redirect_valid_out(redirectValidNv),
        .redirect_ready_in(redirectReady), .redirect_pc_out(redirectPcNv), .mtvec_out(mtvecOutNv),
        .mepc_out(mepcOutNv), .mcause_out(mcauseOutNv), .busy_out(busyNv)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [31:0] legalMtvec(input logic [31:0] oldV, input logic [31:0] newV,
                                               input bit vecEn);
        logic [31:0] base;
        logic [31:0] mode;
        base = (newV / 4) * 4;
        if (newV % 4 == 0) mode = 0;
        else if (newV % 4 == 1 && vecEn) mode = 1;
        else mode = oldV % 4;
        return base + mode;
    endfunction

    function automatic logic [31:0] trapTarget(input logic [31:0] mtvec, input bit isInt,
                                               input logic [3:0] c);
        logic [31:0] base;
        base = (mtvec / 4) * 4;
        if (mtvec % 4 == 1 && isInt) return base + 32'(c) * 32'd4;
        return base;
    endfunction

    function automatic logic [31:0] readModel(input logic [11:0] a);
        if (a == 12'h305) return mtvecModel;
        if (a == 12'h341) return mepcModel;
        if (a == 12'h342) return mcauseModel;
        return 32'h0;
    endfunction

    task automatic modelReset();
        mtvecModel = 0; mtvecModelNv = 0; mepcModel = 0; mcauseModel = 0;
    endtask

    task automatic modelCsrWrite(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h305) begin
            mtvecModel   = legalMtvec(mtvecModel, d, 1'b1);
            mtvecModelNv = legalMtvec(mtvecModelNv, d, 1'b0);
        end else if (a == 12'h341) begin
            mepcModel = (d / 4) * 4;
        end else if (a == 12'h342) begin
            mcauseModel = ((d >> 31) << 31) + (d % 16);
        end
    endtask

    task automatic modelCapture(input bit isInt, input logic [3:0] c, input logic [31:0] p);
        mepcModel   = (p / 4) * 4;
        mcauseModel = (isInt ? 32'h8000_0000 : 32'h0) + 32'(c);
    endtask

    // ---------------- drivers (called at posedge+1, leave at posedge+1) ----------------
    task automatic csrWrite(input logic [11:0] a, input logic [31:0] d);
        csrWrEn = 1'b1; csrAddr = a; csrWrData = d;
        @(posedge clock); #1;
        csrWrEn = 1'b0;
    endtask

    task automatic runTrap(input bit isInt, input logic [3:0] c, input logic [31:0] p,
                           input int readyDelay, input bit wrEn, input logic [11:0] wrAddr,
                           input logic [31:0] wrData, output bit ackSeen,
                           output logic [31:0] pcSeen, output logic [31:0] pcSeenNv,
                           output bit pcStable, output bit endIdle);
        trapReq = 1'b1; intOrExc = isInt; cause = c; pc = p;
        csrWrEn = wrEn; csrAddr = wrAddr; csrWrData = wrData;
        #1 ackSeen = trapAck && !mretAck;
        @(posedge clock); #1;
        trapReq = 1'b0; csrWrEn = 1'b0;
        pcSeen = redirectPc; pcSeenNv = redirectPcNv;
        pcStable = redirectValid && redirectValidNv && !trapAck;
        for (int k = 0; k < readyDelay; k++) begin
            @(posedge clock); #1;
            if (!redirectValid || redirectPc !== pcSeen || trapAck) pcStable = 1'b0;
        end
        redirectReady = 1'b1;
        @(posedge clock); #1;
        redirectReady = 1'b0;
        endIdle = !redirectValid && !busy && !redirectValidNv;
    endtask

    task automatic runMret(input int readyDelay, input bit wrEn, input logic [11:0] wrAddr,
                           input logic [31:0] wrData, output bit ackSeen,
                           output logic [31:0] pcSeen, output bit pcStable, output bit endIdle);
        mretReq = 1'b1;
        csrWrEn = wrEn; csrAddr = wrAddr; csrWrData = wrData;
        #1 ackSeen = mretAck && !trapAck;
        @(posedge clock); #1;
        mretReq = 1'b0; csrWrEn = 1'b0;
        pcSeen = redirectPc;
        pcStable = redirectValid && !mretAck;
        for (int k = 0; k < readyDelay; k++) begin
            @(posedge clock); #1;
            if (!redirectValid || redirectPc !== pcSeen || mretAck) pcStable = 1'b0;
        end
        redirectReady = 1'b1;
        @(posedge clock); #1;
        redirectReady = 1'b0;
        endIdle = !redirectValid && !busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [11:0] addrs [4];
        addrs = '{12'h305, 12'h341, 12'h342, 12'h7C0};
        rstN = 1'b1;
        #1 rstN = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock); rstN = 1'b1;
        @(posedge clock); #1;
        modelReset();
        for (int i = 0; i < 4; i++) begin
            csrAddr = addrs[i];
            #1;
            nCompared++;
            if (csrRdData !== 32'h0) begin
                nMismatched++;
                $display("[TB] FAIL reset_read addr=%h got %h expected 00000000", addrs[i], csrRdData);
            end
        end
        nCompared++;
        if (busy !== 1'b0 || redirectValid !== 1'b0 || redirectPc !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_fsm got busy=%b valid=%b pc=%h expected 0 0 00000000",
                     busy, redirectValid, redirectPc);
        end
    endtask

    task automatic test_direct_trap();
        bit ack, stable, idle;
        logic [31:0] p, pNv;
        csrWrite(12'h305, 32'h8000_0101);
        modelCsrWrite(12'h305, 32'h8000_0101);
        runTrap(1'b0, 4'd5, 32'h0000_1006, 1, 1'b0, 12'h0, 32'h0, ack, p, pNv, stable, idle);
        modelCapture(1'b0, 4'd5, 32'h0000_1006);
        nCompared++;
        if (!ack || !stable || !idle) begin
            nMismatched++;
            $display("[TB] FAIL direct_handshake got ack=%b stable=%b idle=%b expected 1 1 1", ack, stable, idle);
        end
        nCompared++;
        if (p !== 32'h8000_0100 || pNv !== 32'h8000_0100) begin
            nMismatched++;
            $display("[TB] FAIL direct_target got %h/%h expected 80000100", p, pNv);
        end
        nCompared++;
        if (mepcOut !== 32'h0000_1004 || mcauseOut !== 32'h0000_0005) begin
            nMismatched++;
            $display("[TB] FAIL direct_context got mepc=%h mcause=%h expected 00001004 00000005",
                     mepcOut, mcauseOut);
        end
    endtask

    task automatic test_vectored();
        bit ack, stable, idle;
        logic [31:0] p, pNv;
        runTrap(1'b1, 4'd7, 32'h0000_2000, 0, 1'b0, 12'h0, 32'h0, ack, p, pNv, stable, idle);
        modelCapture(1'b1, 4'd7, 32'h0000_2000);
        nCompared++;
        if (p !== 32'h8000_011C || !ack || !idle) begin
            nMismatched++;
            $display("[TB] FAIL vectored_target got %h ack=%b idle=%b expected 8000011c 1 1", p, ack, idle);
        end
        nCompared++;
        if (pNv !== 32'h8000_0100) begin
            nMismatched++;
            $display("[TB] FAIL novec_target got %h expected 80000100", pNv);
        end
        nCompared++;
        if (mcauseOut !== 32'h8000_0007) begin
            nMismatched++;
            $display("[TB] FAIL vectored_mcause got %h expected 80000007", mcauseOut);
        end
    endtask

    task automatic test_wrap_and_warl();
        bit ack, stable, idle;
        logic [31:0] p, pNv;
        csrWrite(12'h305, 32'hFFFF_FFFD);
        modelCsrWrite(12'h305, 32'hFFFF_FFFD);
        runTrap(1'b1, 4'd15, 32'h0000_3000, 2, 1'b0, 12'h0, 32'h0, ack, p, pNv, stable, idle);
        modelCapture(1'b1, 4'd15, 32'h0000_3000);
        nCompared++;
        if (p !== 32'h0000_0038 || pNv !== 32'hFFFF_FFFC) begin
            nMismatched++;
            $display("[TB] FAIL wrap_target got %h/%h expected 00000038/fffffffc", p, pNv);
        end
        csrWrite(12'h305, 32'hFFFF_FFFF);
        modelCsrWrite(12'h305, 32'hFFFF_FFFF);
        nCompared++;
        if (mtvecOut !== 32'hFFFF_FFFD || mtvecOutNv !== 32'hFFFF_FFFC) begin
            nMismatched++;
            $display("[TB] FAIL warl_mode11 got %h/%h expected fffffffd/fffffffc", mtvecOut, mtvecOutNv);
        end
        csrWrite(12'h305, 32'h1234_5602);
        modelCsrWrite(12'h305, 32'h1234_5602);
        nCompared++;
        if (mtvecOut !== 32'h1234_5601 || mtvecOutNv !== 32'h1234_5600) begin
            nMismatched++;
            $display("[TB] FAIL warl_mode10 got %h/%h expected 12345601/12345600", mtvecOut, mtvecOutNv);
        end
    endtask

    task automatic test_trap_mret_collision();
        logic [31:0] expTrap, expMret;
        bit stableOk, sawMretAck;
        expTrap = trapTarget(mtvecModel, 1'b0, 4'd11);
        trapReq = 1'b1; mretReq = 1'b1; intOrExc = 1'b0; cause = 4'd11; pc = 32'h2000_0043;
        #1;
        nCompared++;
        if (trapAck !== 1'b1 || mretAck !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL collision_ack got trap=%b mret=%b expected 1 0", trapAck, mretAck);
        end
        @(posedge clock); #1;
        trapReq = 1'b0;
        modelCapture(1'b0, 4'd11, 32'h2000_0043);
        stableOk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (!redirectValid || redirectPc !== expTrap || mretAck || trapAck) stableOk = 1'b0;
            if (k == 0) begin
                csrWrEn = 1'b1; csrAddr = 12'h342; csrWrData = 32'hFFFF_FFFF;
            end
            @(posedge clock); #1;
            csrWrEn = 1'b0;
        end
        modelCsrWrite(12'h342, 32'hFFFF_FFFF);
        nCompared++;
        if (!stableOk) begin
            nMismatched++;
            $display("[TB] FAIL collision_hold got unstable redirect expected pc %h held 3 cycles", expTrap);
        end
        nCompared++;
        if (mcauseOut !== mcauseModel) begin
            nMismatched++;
            $display("[TB] FAIL write_in_redirect got %h expected %h", mcauseOut, mcauseModel);
        end
        redirectReady = 1'b1;
        @(posedge clock); #1;
        redirectReady = 1'b0;
        sawMretAck = mretAck;
        nCompared++;
        if (!sawMretAck || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL collision_mret_ack got ack=%b busy=%b expected 1 0", sawMretAck, busy);
        end
        expMret = mepcModel;
        @(posedge clock); #1;
        mretReq = 1'b0;
        nCompared++;
        if (redirectValid !== 1'b1 || redirectPc !== expMret) begin
            nMismatched++;
            $display("[TB] FAIL collision_mret_pc got valid=%b pc=%h expected 1 %h", redirectValid, redirectPc, expMret);
        end
        redirectReady = 1'b1;
        @(posedge clock); #1;
        redirectReady = 1'b0;
    endtask

    task automatic test_concurrent_csr();
        bit ack, stable, idle;
        logic [31:0] p, pNv, exp, expNv;
        exp = trapTarget(mtvecModel, 1'b1, 4'd3);
        expNv = trapTarget(mtvecModelNv, 1'b1, 4'd3);
        runTrap(1'b1, 4'd3, 32'h0000_4444, 1, 1'b1, 12'h305, 32'h4000_0001, ack, p, pNv, stable, idle);
        modelCsrWrite(12'h305, 32'h4000_0001);
        modelCapture(1'b1, 4'd3, 32'h0000_4444);
        nCompared++;
        if (p !== exp || pNv !== expNv || mtvecOut !== mtvecModel) begin
            nMismatched++;
            $display("[TB] FAIL trap_with_mtvec_write got pc=%h/%h mtvec=%h expected %h/%h %h",
                     p, pNv, mtvecOut, exp, expNv, mtvecModel);
        end
        runTrap(1'b0, 4'd9, 32'h0000_5557, 0, 1'b1, 12'h341, 32'hDEAD_BEEF, ack, p, pNv, stable, idle);
        modelCsrWrite(12'h341, 32'hDEAD_BEEF);
        modelCapture(1'b0, 4'd9, 32'h0000_5557);
        nCompared++;
        if (mepcOut !== 32'h0000_5554) begin
            nMismatched++;
            $display("[TB] FAIL trap_with_mepc_write got %h expected 00005554", mepcOut);
        end
        exp = mepcModel;
        runMret(1, 1'b1, 12'h341, 32'h1234_5678, ack, p, stable, idle);
        modelCsrWrite(12'h341, 32'h1234_5678);
        nCompared++;
        if (p !== exp || !ack || mepcOut !== 32'h1234_5678) begin
            nMismatched++;
            $display("[TB] FAIL mret_with_mepc_write got pc=%h ack=%b mepc=%h expected %h 1 12345678",
                     p, ack, mepcOut, exp);
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [4];
        bit ack, stable, idle, isInt, wrEn;
        logic [31:0] p, pNv, exp, expNv, d, pcR;
        logic [11:0] a;
        logic [3:0] c;
        int delay;
        addrs = '{12'h305, 12'h341, 12'h342, 12'h300};
        for (int it = 0; it < 60; it++) begin
            a = addrs[$urandom_range(0, 3)];
            d = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    csrWrite(a, d);
                    modelCsrWrite(a, d);
                    csrAddr = addrs[$urandom_range(0, 3)];
                    #1;
                    nCompared++;
                    if (csrRdData !== readModel(csrAddr)) begin
                        nMismatched++;
                        $display("[TB] FAIL rand_read it=%0d addr=%h got %h expected %h",
                                 it, csrAddr, csrRdData, readModel(csrAddr));
                    end
                end
                1: begin
                    isInt = 1'($urandom_range(0, 1));
                    c = 4'($urandom_range(0, 15));
                    pcR = $urandom;
                    delay = $urandom_range(0, 3);
                    wrEn = 1'($urandom_range(0, 1));
                    exp = trapTarget(mtvecModel, isInt, c);
                    expNv = trapTarget(mtvecModelNv, isInt, c);
                    runTrap(isInt, c, pcR, delay, wrEn, a, d, ack, p, pNv, stable, idle);
                    if (wrEn) modelCsrWrite(a, d);
                    modelCapture(isInt, c, pcR);
                    nCompared++;
                    if (!ack || !stable || !idle || p !== exp || pNv !== expNv) begin
                        nMismatched++;
                        $display("[TB] FAIL rand_trap it=%0d got ack=%b stable=%b idle=%b pc=%h/%h expected 1 1 1 %h/%h",
                                 it, ack, stable, idle, p, pNv, exp, expNv);
                    end
                end
                default: begin
                    delay = $urandom_range(0, 3);
                    wrEn = 1'($urandom_range(0, 1));
                    exp = mepcModel;
                    runMret(delay, wrEn, a, d, ack, p, stable, idle);
                    if (wrEn) modelCsrWrite(a, d);
                    nCompared++;
                    if (!ack || !stable || !idle || p !== exp) begin
                        nMismatched++;
                        $display("[TB] FAIL rand_mret it=%0d got ack=%b stable=%b idle=%b pc=%h expected 1 1 1 %h",
                                 it, ack, stable, idle, p, exp);
                    end
                end
            endcase
            nCompared++;
            if (mtvecOut !== mtvecModel || mtvecOutNv !== mtvecModelNv ||
                mepcOut !== mepcModel || mcauseOut !== mcauseModel) begin
                nMismatched++;
                $display("[TB] FAIL rand_regs it=%0d got %h/%h %h %h expected %h/%h %h %h", it,
                         mtvecOut, mtvecOutNv, mepcOut, mcauseOut,
                         mtvecModel, mtvecModelNv, mepcModel, mcauseModel);
            end
        end
    endtask

    task automatic test_reset_mid_redirect();
        trapReq = 1'b1; intOrExc = 1'b0; cause = 4'd2; pc = 32'h0000_0100;
        @(posedge clock); #1;
        trapReq = 1'b0;
        nCompared++;
        if (redirectValid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL pre_reset_valid got %b expected 1", redirectValid);
        end
        #2 rstN = 1'b0;
        #1;
        nCompared++;
        if (redirectValid !== 1'b0 || busy !== 1'b0 || redirectPc !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset_fsm got valid=%b busy=%b pc=%h expected 0 0 00000000",
                     redirectValid, busy, redirectPc);
        end
        nCompared++;
        if (mtvecOut !== 32'h0 || mepcOut !== 32'h0 || mcauseOut !== 32'h0 || mtvecOutNv !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset_regs got %h %h %h expected 0 0 0", mtvecOut, mepcOut, mcauseOut);
        end
        @(posedge clock);
        @(negedge clock); rstN = 1'b1;
        @(posedge clock); #1;
        modelReset();
    endtask

    initial begin
        test_reset();
        test_direct_trap();
        test_vectored();
        test_wrap_and_warl();
        test_trap_mret_collision();
        test_concurrent_csr();
        test_random();
        test_reset_mid_redirect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
